// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out streamer with a valid/ready load port,
// a one-word holding buffer for gap-free back-to-back words, selectable bit
// order and an external bit-rate strobe. data_out, frame_out and done_out
// are all registered so the framing logic downstream sees clean levels.
module piso_stream #(
  parameter int unsigned SIZE      = 8,    // bits per word, 2..64
  parameter bit          MSB_FIRST = 1'b1  // 1: bit SIZE-1 first, 0: bit 0 first
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic [SIZE-1:0] data_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic            shift_en_in,
  output logic            data_out,
  output logic            frame_out,
  output logic            done_out
);

  // Bits-remaining counter: wide enough to hold SIZE-1 for any legal SIZE.
  localparam int unsigned         CNT_W    = $clog2(SIZE) + 1;
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,  // nothing on the line, frame_out low
    ST_SHIFT = 1'b1   // a word is being presented bit by bit
  } state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   hold_q, hold_d;          // holding buffer word
  logic              hold_full_q, hold_full_d;
  logic [SIZE-1:0]   shreg_q, shreg_d;        // bits not yet presented
  logic [CNT_W-1:0]  cnt_q, cnt_d;            // bits remaining after current
  logic              data_q, data_d;
  logic              frame_q, frame_d;
  logic              done_q, done_d;

  logic              accept;  // handshake completes at this edge
  logic              load;    // buffer moves into the shift register

  // The bit presented first from a freshly loaded word.
  function automatic logic head_bit(input logic [SIZE-1:0] w);
    return MSB_FIRST ? w[SIZE-1] : w[0];
  endfunction

  // Drop the bit just presented and zero-fill from the far end.
  function automatic logic [SIZE-1:0] advance(input logic [SIZE-1:0] w);
    return MSB_FIRST ? {w[SIZE-2:0], 1'b0} : {1'b0, w[SIZE-1:1]};
  endfunction

  // ready_out comes straight from the flag register, never from valid_in.
  assign ready_out = !hold_full_q;
  assign accept    = valid_in && !hold_full_q;

  // Holding buffer: capture on handshake, empty on transfer. The two never
  // coincide because a transfer needs the buffer full, which blocks accept.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  // Next-state and serial datapath: each strobe tick advances one bit; the
  // final tick either reloads from the buffer or drops the frame.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (shift_en_in && hold_full_q) begin
          load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (shift_en_in) begin
          if (cnt_q != '0) begin
            data_d  = head_bit(shreg_q);
            shreg_d = advance(shreg_q);
            cnt_d   = cnt_q - CNT_ONE;
          end else begin
            // Last bit's period ends on this tick.
            done_d = 1'b1;
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              data_d  = 1'b0;
              frame_d = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A load is identical from IDLE and from the end of a word, which is
    // what keeps back-to-back words gap-free.
    if (load) begin
      data_d  = head_bit(hold_q);
      shreg_d = advance(hold_q);
      cnt_d   = LAST_CNT;
      frame_d = 1'b1;
      state_d = ST_SHIFT;
    end
  end

  // State register and datapath flops; reset clears outputs immediately.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      data_q      <= 1'b0;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, regardless of statement order.
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      frame_q     <= frame_d;
      done_q      <= done_d;
    end
  end

  assign data_out  = data_q;
  assign frame_out = frame_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: drives an MSB-first and an LSB-first instance from the
// same stimulus and compares both, every cycle, against a word/bit-queue
// reference model; directed scenarios add end-to-end checks on the
// captured serial stream, framing length and done pulses.
module tb_piso_stream;

  localparam int SIZE = 8;

  logic            clk;
  logic            rst_n;
  logic [SIZE-1:0] data_in;
  logic            valid_in;
  logic            shift_en;

  logic dm, fm, dnm, rm;  // MSB-first instance outputs
  logic dl, fl, dnl, rl;  // LSB-first instance outputs

  piso_stream #(.SIZE(SIZE), .MSB_FIRST(1'b1)) u_msb (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (rm),
    .shift_en_in(shift_en),
    .data_out   (dm),
    .frame_out  (fm),
    .done_out   (dnm)
  );

  piso_stream #(.SIZE(SIZE), .MSB_FIRST(1'b0)) u_lsb (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (rl),
    .shift_en_in(shift_en),
    .data_out   (dl),
    .frame_out  (fl),
    .done_out   (dnl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Accepted-but-not-started words, and the bits of the current word still
  // to be shown after the one on the line (one queue per bit order).
  logic [SIZE-1:0] pend[$];
  bit              bq_m[$];
  bit              bq_l[$];
  bit              m_frame, m_dm, m_dl, m_done, m_acc;

  task automatic model_reset();
    pend.delete();
    bq_m.delete();
    bq_l.delete();
    m_frame = 0;
    m_dm    = 0;
    m_dl    = 0;
    m_done  = 0;
    m_acc   = 0;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_update();
    bit              acc;
    logic [SIZE-1:0] w;
    acc    = valid_in && (pend.size() == 0);
    m_done = 0;
    if (shift_en) begin
      if (m_frame) begin
        if (bq_m.size() > 0) begin
          m_dm = bq_m.pop_front();
          m_dl = bq_l.pop_front();
        end else begin
          m_done  = 1;
          m_frame = 0;
          m_dm    = 0;
          m_dl    = 0;
        end
      end
      if (!m_frame && pend.size() > 0) begin
        w = pend.pop_front();
        for (int i = SIZE - 1; i >= 0; i--) bq_m.push_back(w[i]);
        for (int i = 0; i < SIZE; i++) bq_l.push_back(w[i]);
        m_dm    = bq_m.pop_front();
        m_dl    = bq_l.pop_front();
        m_frame = 1;
      end
    end
    if (acc) pend.push_back(data_in);
    m_acc = acc;
  endtask

  // ---------------- observation ----------------
  logic [63:0] cap_m, cap_l;   // serial bits seen while framed, newest in LSB
  int          n_cap, done_cnt, rise_cnt, cyc;
  logic        prev_fm;
  int          strobe_mode;    // 0: every cycle, 1: every 4th, 2: random

  task automatic clear_obs();
    cap_m    = '0;
    cap_l    = '0;
    n_cap    = 0;
    done_cnt = 0;
    rise_cnt = 0;
  endtask

  // One clock: update the model at the edge, compare 1 time unit later,
  // then set the strobe for the next edge.
  task automatic cycle();
    logic exp_ready;
    @(posedge clk);
    model_update();
    #1;
    exp_ready = (pend.size() == 0);
    check("msb_data",  dm,  m_dm);
    check("msb_frame", fm,  m_frame);
    check("msb_done",  dnm, m_done);
    check("msb_ready", rm,  exp_ready);
    check("lsb_data",  dl,  m_dl);
    check("lsb_frame", fl,  m_frame);
    check("lsb_done",  dnl, m_done);
    check("lsb_ready", rl,  exp_ready);
    if (fm) begin
      cap_m = {cap_m[62:0], dm};
      n_cap++;
    end
    if (fl) cap_l = {cap_l[62:0], dl};
    if (dnm) done_cnt++;
    if (fm && !prev_fm) rise_cnt++;
    prev_fm = fm;
    cyc++;
    case (strobe_mode)
      0:       shift_en = 1'b1;
      1:       shift_en = (cyc % 4 == 0);
      default: shift_en = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Hold valid until the model accepts the word; returns edges taken.
  task automatic send(input logic [SIZE-1:0] w, output int n);
    n        = 0;
    data_in  = w;
    valid_in = 1'b1;
    do begin
      cycle();
      n++;
    end while (!m_acc && n < 200);
    check("send_accepted", m_acc, 1'b1);
    valid_in = 1'b0;
    data_in  = SIZE'($urandom);  // later changes must not matter
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_msb_data"},  dm,  1'b0);
    check({tag, "_msb_frame"}, fm,  1'b0);
    check({tag, "_msb_done"},  dnm, 1'b0);
    check({tag, "_msb_ready"}, rm,  1'b1);
    check({tag, "_lsb_data"},  dl,  1'b0);
    check({tag, "_lsb_frame"}, fl,  1'b0);
    check({tag, "_lsb_done"},  dnl, 1'b0);
    check({tag, "_lsb_ready"}, rl,  1'b1);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7 - i];
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int              n;
    logic [SIZE-1:0] w1, w2, w3;

    rst_n       = 1'b0;
    valid_in    = 1'b0;
    data_in     = '0;
    shift_en    = 1'b0;
    strobe_mode = 0;
    cyc         = 0;
    prev_fm     = 1'b0;
    model_reset();
    clear_obs();

    // Reset values, then release between edges.
    #3;
    check_reset_state("por");
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n    = 1'b1;
    shift_en = 1'b1;
    run(2);

    // Single word 0xA5: both orders give 1,0,1,0,0,1,0,1.
    clear_obs();
    send(8'hA5, n);
    run(12);
    check("a5_msb_bits",  cap_m[7:0], 8'hA5);
    check("a5_lsb_bits",  cap_l[7:0], 8'hA5);
    check("a5_frame_len", n_cap, 8);
    check("a5_done_cnt",  done_cnt, 1);

    // Back-to-back 0x3C then 0xC3 accepted mid-frame: 16 contiguous bits.
    clear_obs();
    send(8'h3C, n);
    run(3);
    send(8'hC3, n);
    run(20);
    check("b2b_msb_bits",  cap_m[15:0], 16'h3CC3);
    check("b2b_lsb_bits",  cap_l[15:0], {rev8(8'h3C), rev8(8'hC3)});
    check("b2b_frame_len", n_cap, 16);
    check("b2b_frame_gap", rise_cnt, 1);
    check("b2b_done_cnt",  done_cnt, 2);

    // Sparse strobe, every 4th cycle, 0x81: each bit held 4 cycles.
    strobe_mode = 1;
    clear_obs();
    send(8'h81, n);
    run(60);
    check("sparse_msb_bits",  cap_m[31:0], 32'hF000000F);
    check("sparse_lsb_bits",  cap_l[31:0], 32'hF000000F);
    check("sparse_frame_len", n_cap, 32);
    check("sparse_done_cnt",  done_cnt, 1);

    // Backpressure: third word waits until the buffered one moves on.
    strobe_mode = 0;
    run(2);
    clear_obs();
    w1 = SIZE'($urandom);
    w2 = SIZE'($urandom);
    w3 = SIZE'($urandom);
    send(w1, n);
    send(w2, n);
    check("bp_second_wait", n, 2);
    send(w3, n);
    check("bp_third_wait", n, 8);
    run(30);
    check("bp_msb_bits",  cap_m[23:0], {w1, w2, w3});
    check("bp_lsb_bits",  cap_l[23:0], {rev8(w1), rev8(w2), rev8(w3)});
    check("bp_frame_len", n_cap, 24);
    check("bp_frame_gap", rise_cnt, 1);
    check("bp_done_cnt",  done_cnt, 3);

    // Reset mid-frame with a second word buffered: both are discarded.
    clear_obs();
    send(8'hFF, n);
    send(8'h55, n);
    for (int i = 0; i < 20 && n_cap < 3; i++) cycle();
    check("rst_bits_before", n_cap, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_async");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_state("rst_held");
    #2;
    rst_n = 1'b1;
    clear_obs();
    run(6);
    check("rst_discarded", n_cap, 0);
    send(8'h01, n);
    run(12);
    check("rst_msb_bits",  cap_m[7:0], 8'h01);
    check("rst_lsb_bits",  cap_l[7:0], 8'h80);
    check("rst_frame_len", n_cap, 8);
    check("rst_done_cnt",  done_cnt, 1);

    // Random traffic and strobe against the model.
    strobe_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      valid_in = ($urandom_range(0, 1) == 1);
      data_in  = SIZE'($urandom);
      cycle();
    end
    valid_in = 1'b0;
    strobe_mode = 0;
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
